alu_share_arb: RTL and testbench

- Arbitrates the single combinational 8-bit ALU between two requesters: port 0 is the core execute path, port 1 is the multi-cycle helper or debug path.
- Each accepted request is latched, driven to the ALU for one EXEC cycle, and its result is registered and held for the owning requester until consumed.
- Sits between the requesters and the ALU instance. No ALU decode is duplicated here: the ALU outputs are captured as they are.

---
 rtl/alu_share_arb.sv | 173 +++++++++++++++++
 tb/tb_alu_share_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational 8-bit ALU between the core execute
// path (port 0) and the helper/debug path (port 1). Each accepted request is
// latched, presented to the ALU for one EXEC cycle, and its result is held in
// a per-port response register until that requester consumes it.
module alu_share_arb #(
   parameter int FIXED_PRIO = 0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [3:0]       req0_cmd,
   input  logic [7:0]       req0_a,
   input  logic [7:0]       req0_b,
   input  logic             req0_sc,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [3:0]       req1_cmd,
   input  logic [7:0]       req1_a,
   input  logic [7:0]       req1_b,
   input  logic             req1_sc,
   output logic             req1_ready,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [7:0]       rsp0_rslt,
   output logic [2:0]       rsp0_flags,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [7:0]       rsp1_rslt,
   output logic [2:0]       rsp1_flags,
   output logic [CNT_W-1:0] done0_cnt,
   output logic [CNT_W-1:0] done1_cnt,
   output logic [3:0]       alu_cmd,
   output logic [7:0]       alu_inA,
   output logic [7:0]       alu_inB,
   output logic             alu_sc_i,
   input  logic [7:0]       alu_rslt,
   input  logic             alu_sc_o,
   input  logic             alu_pari,
   input  logic             alu_one,
   output logic             busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EXEC = 1'b1;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [0:0] state;
   logic [3:0] op_cmd;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       op_sc;
   logic       owner;
   logic       last_grant;

   logic       elig0;
   logic       elig1;
   logic       grant;
   logic       accept;

   // A port with an unconsumed response is never granted; ties are broken by
   // fixed priority or by alternating away from the last granted port.
   always_comb begin
      elig0 = req0_valid && !rsp0_valid;
      elig1 = req1_valid && !rsp1_valid;
      grant = 1'b0;
      if (elig0 && !elig1) begin
         grant = 1'b0;
      end else if (elig1 && !elig0) begin
         grant = 1'b1;
      end else if (FIXED_PRIO != 0) begin
         grant = 1'b0;
      end else begin
         grant = ~last_grant;
      end
      req0_ready = rst_n && (state == ST_IDLE) && !grant && elig0;
      req1_ready = rst_n && (state == ST_IDLE) &&  grant && elig1;
      accept     = req0_ready || req1_ready;
   end

   // ALU inputs come from the operand registers only during EXEC, zero otherwise.
   always_comb begin
      busy     = (state == ST_EXEC);
      alu_cmd  = busy ? op_cmd : 4'b0000;
      alu_inA  = busy ? op_a   : 8'h00;
      alu_inB  = busy ? op_b   : 8'h00;
      alu_sc_i = busy ? op_sc  : 1'b0;
   end

   // Two-state sequencer: latch the granted request on accept, then spend one EXEC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         op_cmd     <= 4'b0000;
         op_a       <= 8'h00;
         op_b       <= 8'h00;
         op_sc      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state      <= ST_EXEC;
                  owner      <= grant;
                  last_grant <= grant;
                  op_cmd     <= grant ? req1_cmd : req0_cmd;
                  op_a       <= grant ? req1_a   : req0_a;
                  op_b       <= grant ? req1_b   : req0_b;
                  op_sc      <= grant ? req1_sc  : req0_sc;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Port 0 response register: capture at the end of its EXEC, clear on consumption.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid <= 1'b0;
         rsp0_rslt  <= 8'h00;
         rsp0_flags <= 3'b000;
      end else begin
         if (rsp0_valid && rsp0_ready) begin
            rsp0_valid <= 1'b0;
         end
         if ((state == ST_EXEC) && !owner) begin
            rsp0_valid <= 1'b1;
            rsp0_rslt  <= alu_rslt;
            rsp0_flags <= {alu_sc_o, alu_pari, alu_one};
         end
      end
   end

   // Port 1 response register: capture at the end of its EXEC, clear on consumption.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp1_valid <= 1'b0;
         rsp1_rslt  <= 8'h00;
         rsp1_flags <= 3'b000;
      end else begin
         if (rsp1_valid && rsp1_ready) begin
            rsp1_valid <= 1'b0;
         end
         if ((state == ST_EXEC) && owner) begin
            rsp1_valid <= 1'b1;
            rsp1_rslt  <= alu_rslt;
            rsp1_flags <= {alu_sc_o, alu_pari, alu_one};
         end
      end
   end

   // Saturating counts of responses each port has consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done0_cnt <= '0;
         done1_cnt <= '0;
      end else begin
         if (rsp0_valid && rsp0_ready && (done0_cnt != CNT_MAX)) begin
            done0_cnt <= done0_cnt + CNT_ONE;
         end
         if (rsp1_valid && rsp1_ready && (done1_cnt != CNT_MAX)) begin
            done1_cnt <= done1_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: two instances (round-robin/16-bit counters and
// fixed-priority/2-bit counters), each wired to a small ALU model, with a
// scoreboard of expected responses per instance and port.
module tb_alu_share_arb;

   logic clk = 1'b0;
   logic rst_n;

   // Generates the 10-unit system clock.
   always #5 clk = ~clk;

   logic       rq_valid [2][2];
   logic [3:0] rq_cmd   [2][2];
   logic [7:0] rq_a     [2][2];
   logic [7:0] rq_b     [2][2];
   logic       rq_sc    [2][2];
   logic       rs_ready [2][2];

   logic       rq_ready [2][2];
   logic       rs_valid [2][2];
   logic [7:0] rs_rslt  [2][2];
   logic [2:0] rs_flags [2][2];
   logic [15:0] done_v  [2][2];
   logic [3:0] alu_cmd_v [2];
   logic [7:0] alu_a_v   [2];
   logic [7:0] alu_b_v   [2];
   logic       alu_sc_v  [2];
   logic       busy_v    [2];

   logic        u0_req0_ready, u0_req1_ready, u0_rsp0_valid, u0_rsp1_valid;
   logic [7:0]  u0_rsp0_rslt, u0_rsp1_rslt;
   logic [2:0]  u0_rsp0_flags, u0_rsp1_flags;
   logic [15:0] u0_done0, u0_done1;
   logic [3:0]  u0_alu_cmd;
   logic [7:0]  u0_alu_a, u0_alu_b, u0_alu_r;
   logic        u0_alu_sci, u0_alu_sco, u0_alu_par, u0_alu_one, u0_busy;

   logic        u1_req0_ready, u1_req1_ready, u1_rsp0_valid, u1_rsp1_valid;
   logic [7:0]  u1_rsp0_rslt, u1_rsp1_rslt;
   logic [2:0]  u1_rsp0_flags, u1_rsp1_flags;
   logic [1:0]  u1_done0, u1_done1;
   logic [3:0]  u1_alu_cmd;
   logic [7:0]  u1_alu_a, u1_alu_b, u1_alu_r;
   logic        u1_alu_sci, u1_alu_sco, u1_alu_par, u1_alu_one, u1_busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [10:0] exp_q [4][$];
   int          gseq [$];
   int          gcnt [2][2];
   int          cons [2][2];
   logic        tb_last [2];
   logic [20:0] inflight [2];

   // Reference ALU: returns {sc_o, pari, one, rslt}.
   function automatic logic [10:0] alu_f(input logic [3:0] c, input logic [7:0] a,
                                         input logic [7:0] b, input logic s);
      logic [8:0] t;
      t = 9'd0;
      case (c)
         4'd0: t = {1'b0, a} + {1'b0, b} + {8'd0, s};
         4'd1: t = {1'b0, a} - {1'b0, b} - {8'd0, s};
         4'd2: t = {1'b0, a & b};
         4'd3: t = {1'b0, a | b};
         4'd4: t = {1'b0, a ^ b};
         4'd5: t = {a, s};
         default: t = {1'b0, a};
      endcase
      return {t[8], ^t[7:0], (t[7:0] == 8'h01), t[7:0]};
   endfunction

   assign {u0_alu_sco, u0_alu_par, u0_alu_one, u0_alu_r} = alu_f(u0_alu_cmd, u0_alu_a, u0_alu_b, u0_alu_sci);
   assign {u1_alu_sco, u1_alu_par, u1_alu_one, u1_alu_r} = alu_f(u1_alu_cmd, u1_alu_a, u1_alu_b, u1_alu_sci);

   alu_share_arb #(.FIXED_PRIO(0), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(rq_valid[0][0]), .req0_cmd(rq_cmd[0][0]), .req0_a(rq_a[0][0]),
      .req0_b(rq_b[0][0]), .req0_sc(rq_sc[0][0]), .req0_ready(u0_req0_ready),
      .req1_valid(rq_valid[0][1]), .req1_cmd(rq_cmd[0][1]), .req1_a(rq_a[0][1]),
      .req1_b(rq_b[0][1]), .req1_sc(rq_sc[0][1]), .req1_ready(u0_req1_ready),
      .rsp0_valid(u0_rsp0_valid), .rsp0_ready(rs_ready[0][0]), .rsp0_rslt(u0_rsp0_rslt),
      .rsp0_flags(u0_rsp0_flags),
      .rsp1_valid(u0_rsp1_valid), .rsp1_ready(rs_ready[0][1]), .rsp1_rslt(u0_rsp1_rslt),
      .rsp1_flags(u0_rsp1_flags),
      .done0_cnt(u0_done0), .done1_cnt(u0_done1),
      .alu_cmd(u0_alu_cmd), .alu_inA(u0_alu_a), .alu_inB(u0_alu_b), .alu_sc_i(u0_alu_sci),
      .alu_rslt(u0_alu_r), .alu_sc_o(u0_alu_sco), .alu_pari(u0_alu_par), .alu_one(u0_alu_one),
      .busy(u0_busy)
   );

   alu_share_arb #(.FIXED_PRIO(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(rq_valid[1][0]), .req0_cmd(rq_cmd[1][0]), .req0_a(rq_a[1][0]),
      .req0_b(rq_b[1][0]), .req0_sc(rq_sc[1][0]), .req0_ready(u1_req0_ready),
      .req1_valid(rq_valid[1][1]), .req1_cmd(rq_cmd[1][1]), .req1_a(rq_a[1][1]),
      .req1_b(rq_b[1][1]), .req1_sc(rq_sc[1][1]), .req1_ready(u1_req1_ready),
      .rsp0_valid(u1_rsp0_valid), .rsp0_ready(rs_ready[1][0]), .rsp0_rslt(u1_rsp0_rslt),
      .rsp0_flags(u1_rsp0_flags),
      .rsp1_valid(u1_rsp1_valid), .rsp1_ready(rs_ready[1][1]), .rsp1_rslt(u1_rsp1_rslt),
      .rsp1_flags(u1_rsp1_flags),
      .done0_cnt(u1_done0), .done1_cnt(u1_done1),
      .alu_cmd(u1_alu_cmd), .alu_inA(u1_alu_a), .alu_inB(u1_alu_b), .alu_sc_i(u1_alu_sci),
      .alu_rslt(u1_alu_r), .alu_sc_o(u1_alu_sco), .alu_pari(u1_alu_par), .alu_one(u1_alu_one),
      .busy(u1_busy)
   );

   assign rq_ready[0][0] = u0_req0_ready;  assign rq_ready[0][1] = u0_req1_ready;
   assign rq_ready[1][0] = u1_req0_ready;  assign rq_ready[1][1] = u1_req1_ready;
   assign rs_valid[0][0] = u0_rsp0_valid;  assign rs_valid[0][1] = u0_rsp1_valid;
   assign rs_valid[1][0] = u1_rsp0_valid;  assign rs_valid[1][1] = u1_rsp1_valid;
   assign rs_rslt[0][0]  = u0_rsp0_rslt;   assign rs_rslt[0][1]  = u0_rsp1_rslt;
   assign rs_rslt[1][0]  = u1_rsp0_rslt;   assign rs_rslt[1][1]  = u1_rsp1_rslt;
   assign rs_flags[0][0] = u0_rsp0_flags;  assign rs_flags[0][1] = u0_rsp1_flags;
   assign rs_flags[1][0] = u1_rsp0_flags;  assign rs_flags[1][1] = u1_rsp1_flags;
   assign done_v[0][0]   = u0_done0;       assign done_v[0][1]   = u0_done1;
   assign done_v[1][0]   = {14'd0, u1_done0};
   assign done_v[1][1]   = {14'd0, u1_done1};
   assign alu_cmd_v[0] = u0_alu_cmd;  assign alu_cmd_v[1] = u1_alu_cmd;
   assign alu_a_v[0]   = u0_alu_a;    assign alu_a_v[1]   = u1_alu_a;
   assign alu_b_v[0]   = u0_alu_b;    assign alu_b_v[1]   = u1_alu_b;
   assign alu_sc_v[0]  = u0_alu_sci;  assign alu_sc_v[1]  = u1_alu_sci;
   assign busy_v[0]    = u0_busy;     assign busy_v[1]    = u1_busy;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard and protocol model, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) exp_q[k].delete();
         for (int i = 0; i < 2; i++) begin
            tb_last[i] = 1'b1;
            for (int p = 0; p < 2; p++) cons[i][p] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            logic e0, e1, w1, x0, x1;
            if (busy_v[i]) begin
               checkOutput("alu drive", {11'd0, alu_cmd_v[i], alu_a_v[i], alu_b_v[i], alu_sc_v[i]},
                           {11'd0, inflight[i]});
            end else begin
               checkOutput("alu idle zero", {11'd0, alu_cmd_v[i], alu_a_v[i], alu_b_v[i], alu_sc_v[i]}, 32'd0);
            end
            e0 = rq_valid[i][0] && !rs_valid[i][0];
            e1 = rq_valid[i][1] && !rs_valid[i][1];
            w1 = (i == 1) ? 1'b0 : !tb_last[i];
            x0 = !busy_v[i] && e0 && !(e1 && w1);
            x1 = !busy_v[i] && e1 && !(e0 && !w1);
            checkOutput("ready0", {31'd0, rq_ready[i][0]}, {31'd0, x0});
            checkOutput("ready1", {31'd0, rq_ready[i][1]}, {31'd0, x1});
            for (int p = 0; p < 2; p++) begin
               if (rq_valid[i][p] && rq_ready[i][p]) begin
                  exp_q[i*2+p].push_back(alu_f(rq_cmd[i][p], rq_a[i][p], rq_b[i][p], rq_sc[i][p]));
                  inflight[i] = {rq_cmd[i][p], rq_a[i][p], rq_b[i][p], rq_sc[i][p]};
                  tb_last[i] = p[0];
                  gcnt[i][p]++;
                  if (i == 0) gseq.push_back(p);
               end
               if (rs_valid[i][p] && rs_ready[i][p]) begin
                  cons[i][p]++;
                  if (exp_q[i*2+p].size() == 0) begin
                     checkOutput("unexpected rsp", 32'd1, 32'd0);
                  end else begin
                     checkOutput("rsp data", {21'd0, rs_flags[i][p], rs_rslt[i][p]},
                                 {21'd0, exp_q[i*2+p].pop_front()});
                  end
               end
            end
         end
      end
   end

   // Presents one request and holds it until accepted (bounded), then drops valid.
   task automatic applyStimulus(input int i, input int p, input logic [3:0] c,
                                input logic [7:0] a, input logic [7:0] b, input logic s);
      bit got;
      got = 1'b0;
      rq_cmd[i][p] = c; rq_a[i][p] = a; rq_b[i][p] = b; rq_sc[i][p] = s;
      rq_valid[i][p] = 1'b1;
      for (int n = 0; n < 30 && !got; n++) begin
         @(negedge clk);
         if (rq_ready[i][p]) got = 1'b1;
      end
      if (!got) checkOutput("accept timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      rq_valid[i][p] = 1'b0;
   endtask

   initial begin
      int g1;
      int n0;
      for (int i = 0; i < 2; i++) begin
         for (int p = 0; p < 2; p++) begin
            rq_valid[i][p] = 1'b0; rq_cmd[i][p] = 4'd0; rq_a[i][p] = 8'd0;
            rq_b[i][p] = 8'd0; rq_sc[i][p] = 1'b0; rs_ready[i][p] = 1'b0;
            gcnt[i][p] = 0; cons[i][p] = 0;
         end
         tb_last[i] = 1'b1;
         inflight[i] = 21'd0;
      end

      // reset state
      rst_n = 1'b0;
      rq_valid[0][0] = 1'b1;
      #12;
      checkOutput("reset ready0", {31'd0, rq_ready[0][0]}, 32'd0);
      checkOutput("reset busy", {31'd0, busy_v[0]}, 32'd0);
      checkOutput("reset rsp valid", {31'd0, rs_valid[0][0]}, 32'd0);
      checkOutput("reset rslt", {24'd0, rs_rslt[0][0]}, 32'd0);
      checkOutput("reset done", {16'd0, done_v[0][0]}, 32'd0);
      rq_valid[0][0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // port 0 single add
      rs_ready[0][0] = 1'b1;
      applyStimulus(0, 0, 4'd0, 8'd5, 8'd3, 1'b0);
      @(negedge clk);
      checkOutput("add busy", {31'd0, busy_v[0]}, 32'd1);
      checkOutput("add alu_cmd", {28'd0, alu_cmd_v[0]}, 32'd0);
      checkOutput("add inA", {24'd0, alu_a_v[0]}, 32'd5);
      checkOutput("add inB", {24'd0, alu_b_v[0]}, 32'd3);
      @(negedge clk);
      checkOutput("add rsp valid", {31'd0, rs_valid[0][0]}, 32'd1);
      checkOutput("add rslt", {24'd0, rs_rslt[0][0]}, 32'd8);
      @(negedge clk);
      checkOutput("add rsp pulse", {31'd0, rs_valid[0][0]}, 32'd0);
      checkOutput("add done", {16'd0, done_v[0][0]}, 32'd1);

      // round-robin contention
      gseq.delete();
      rs_ready[0][1] = 1'b1;
      rq_cmd[0][0] = 4'd1; rq_a[0][0] = 8'd9;    rq_b[0][0] = 8'd4;    rq_sc[0][0] = 1'b0;
      rq_cmd[0][1] = 4'd4; rq_a[0][1] = 8'hF0;   rq_b[0][1] = 8'h3C;   rq_sc[0][1] = 1'b0;
      rq_valid[0][0] = 1'b1; rq_valid[0][1] = 1'b1;
      repeat (16) @(posedge clk);
      #1;
      rq_valid[0][0] = 1'b0; rq_valid[0][1] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("rr grant count", {31'd0, gseq.size() >= 6}, 32'd1);
      for (int k = 1; k < gseq.size(); k++) begin
         checkOutput("rr alternate", gseq[k], (gseq[k-1] == 0) ? 32'd1 : 32'd0);
      end
      checkOutput("rr last rslt0", {24'd0, rs_rslt[0][0]}, 32'd5);
      checkOutput("rr last rslt1", {24'd0, rs_rslt[0][1]}, 32'hCC);

      // counter saturation on the 2-bit instance
      rs_ready[1][1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, 1, 4'd4, 8'(k), 8'h55, 1'b0);
         repeat (3) @(posedge clk);
         #1;
         checkOutput("sat done1", {16'd0, done_v[1][1]}, (k + 1 > 3) ? 32'd3 : 32'(k + 1));
      end

      // fixed-priority contention
      rs_ready[1][0] = 1'b1;
      rq_cmd[1][0] = 4'd3; rq_a[1][0] = 8'h12; rq_b[1][0] = 8'h40; rq_sc[1][0] = 1'b0;
      rq_cmd[1][1] = 4'd0; rq_a[1][1] = 8'hFF; rq_b[1][1] = 8'h01; rq_sc[1][1] = 1'b1;
      n0 = gcnt[1][0];
      rq_valid[1][0] = 1'b1; rq_valid[1][1] = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      rq_valid[1][0] = 1'b0; rq_valid[1][1] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("fp p0 served", {31'd0, (gcnt[1][0] - n0) >= 3}, 32'd1);

      // backpressure on port 0 while port 1 keeps flowing
      rs_ready[0][0] = 1'b0;
      rs_ready[0][1] = 1'b1;
      applyStimulus(0, 0, 4'd2, 8'h0F, 8'h3C, 1'b0);
      rq_cmd[0][0] = 4'd3; rq_a[0][0] = 8'h01; rq_b[0][0] = 8'h02; rq_valid[0][0] = 1'b1;
      rq_cmd[0][1] = 4'd0; rq_a[0][1] = 8'h07; rq_b[0][1] = 8'h01; rq_valid[0][1] = 1'b1;
      g1 = gcnt[0][1];
      repeat (2) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checkOutput("bp hold valid", {31'd0, rs_valid[0][0]}, 32'd1);
         checkOutput("bp hold rslt", {24'd0, rs_rslt[0][0]}, 32'h0C);
         checkOutput("bp no regrant", {31'd0, rq_ready[0][0]}, 32'd0);
      end
      checkOutput("bp p1 served", {31'd0, (gcnt[0][1] - g1) >= 3}, 32'd1);
      @(posedge clk); #1;
      rq_valid[0][1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rs_ready[0][0] = 1'b1;
      @(negedge clk);
      checkOutput("bp consume cycle", {31'd0, rq_ready[0][0]}, 32'd0);
      @(negedge clk);
      checkOutput("bp regrant", {31'd0, rq_ready[0][0]}, 32'd1);
      @(posedge clk); #1;
      rq_valid[0][0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // reset in the EXEC cycle of a shift
      applyStimulus(0, 0, 4'd5, 8'h81, 8'h00, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst busy", {31'd0, busy_v[0]}, 32'd0);
      checkOutput("rst rsp0", {31'd0, rs_valid[0][0]}, 32'd0);
      checkOutput("rst rsp1", {31'd0, rs_valid[0][1]}, 32'd0);
      checkOutput("rst done0", {16'd0, done_v[0][0]}, 32'd0);
      checkOutput("rst done1 sat", {16'd0, done_v[1][1]}, 32'd0);
      rq_valid[0][0] = 1'b1;
      #1;
      checkOutput("rst ready", {31'd0, rq_ready[0][0]}, 32'd0);
      rq_valid[0][0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("rst no rsp", {31'd0, rs_valid[0][0]}, 32'd0);

      // port 0 wins the first tie after reset
      rq_cmd[0][0] = 4'd0; rq_a[0][0] = 8'h20; rq_b[0][0] = 8'h22;
      rq_valid[0][0] = 1'b1; rq_valid[0][1] = 1'b1;
      @(negedge clk);
      checkOutput("first tie p0", {31'd0, rq_ready[0][0]}, 32'd1);
      @(posedge clk); #1;
      rq_valid[0][0] = 1'b0; rq_valid[0][1] = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      for (int i = 0; i < 2; i++) begin
         for (int p = 0; p < 2; p++) begin
            checkOutput("done count", {16'd0, done_v[i][p]},
                        (i == 1 && cons[i][p] > 3) ? 32'd3 : 32'(cons[i][p]));
            checkOutput("sb drained", exp_q[i*2+p].size(), 32'd0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
